// File: rtl/aud_ctrl_pkg.sv
// Shared types for the audio mode controller: output-path modes, settle FSM
// states and the active-low key patterns that select each mode.
package aud_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_NOISY = 2'd1,
    MODE_FIR   = 2'd2,
    MODE_NSAMP = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [2:0] KEY_NOISY = 3'b110;
  localparam logic [2:0] KEY_FIR   = 3'b101;
  localparam logic [2:0] KEY_NSAMP = 3'b011;

  // Exactly one pressed key selects a mode; anything else falls back to RAW.
  function automatic mode_t decode_keys(input logic [2:0] key_n);
    case (key_n)
      KEY_NOISY: decode_keys = MODE_NOISY;
      KEY_FIR:   decode_keys = MODE_FIR;
      KEY_NSAMP: decode_keys = MODE_NSAMP;
      default:   decode_keys = MODE_RAW;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Decodes the mode keys and accepts a request once it has been stable for
// DEB_CYCLES consecutive clocks; pulses accept only when the mode changes.
module key_debounce
  import aud_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  output mode_t      accepted,
  output logic       accept,
  output logic       pending
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  mode_t         req;
  mode_t         prev_req;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // cnt is the number of consecutive clocks the request has held, including
  // the clock in which a new value first appears.
  always_comb begin
    req = decode_keys(key_n);
    if (req != prev_req) begin
      cnt_next = CW'(1);
    end else if (cnt == CNT_MAX) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + 1'b1;
    end
    accept  = ~reset && (cnt_next == CNT_MAX) &&
              ((req != prev_req) || (cnt != CNT_MAX)) && (req != accepted);
    pending = (prev_req != accepted);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_req <= req;
      cnt      <= '0;
      accepted <= MODE_RAW;
    end else begin
      prev_req <= req;
      cnt      <= cnt_next;
      if (accept) begin
        accepted <= req;
      end
    end
  end

endmodule

// File: rtl/audio_mode_ctrl.sv
// Audio path mode controller: codec strobes, debounced mode keys and a mute
// window of SETTLE_SAMPLES strobes after each change (built only with AUD_MODE_SETTLE_EN).
module audio_mode_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES     = 50000,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read_ready,
  input  logic       write_ready,
  input  logic [2:0] key_n,
  output logic       read,
  output logic       write,
  output logic [1:0] mode,
  output logic       mute,
  output logic       busy,
  output state_t     fsm_state
);

  mode_t accepted;
  logic  accept;
  logic  pending;

  assign read  = read_ready & write_ready & ~reset;
  assign write = read_ready & write_ready & ~reset;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .accepted(accepted),
    .accept  (accept),
    .pending (pending)
  );

  assign mode = accepted;

`ifdef AUD_MODE_SETTLE_EN
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_next;
  logic [SW-1:0] scnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      scnt  <= '0;
    end else begin
      state <= state_next;
      scnt  <= scnt_next;
    end
  end

  // A strobe on an accept edge is dropped: the new settle starts from zero.
  always_comb begin
    state_next = state;
    scnt_next  = scnt;
    scnt_inc   = scnt + 1'b1;
    case (state)
      ST_RUN: begin
        if (accept && (SETTLE_SAMPLES != 0)) begin
          state_next = ST_SETTLE;
          scnt_next  = '0;
        end
      end
      ST_SETTLE: begin
        if (accept) begin
          scnt_next = '0;
        end else if (read) begin
          if (scnt != SETTLE_LAST) begin
            scnt_next = scnt_inc;
          end
          if (scnt_inc == SETTLE_LAST) begin
            state_next = ST_RUN;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
        scnt_next  = '0;
      end
    endcase
  end

  assign mute      = (state == ST_SETTLE) & ~reset;
  assign busy      = ~reset & (pending | (state == ST_SETTLE));
  assign fsm_state = state;
`else
  assign mute      = 1'b0;
  assign busy      = ~reset & pending;
  assign fsm_state = ST_RUN;
`endif

endmodule

// File: tb/tb_audio_mode_ctrl.sv
// Directed bench for audio_mode_ctrl (DEB_CYCLES=4, SETTLE_SAMPLES=3) with a
// behavioural model checked every cycle; follows AUD_MODE_SETTLE_EN if defined.
module tb_audio_mode_ctrl;
  import aud_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int SET = 3;
`ifdef AUD_MODE_SETTLE_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       read_ready = 1'b0;
  logic       write_ready = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       read;
  logic       write;
  logic [1:0] mode;
  logic       mute;
  logic       busy;
  state_t     fsm_state;

  always #5 clk = ~clk;

  audio_mode_ctrl #(
    .DEB_CYCLES    (DEB),
    .SETTLE_SAMPLES(SET)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read_ready (read_ready),
    .write_ready(write_ready),
    .key_n      (key_n),
    .read       (read),
    .write      (write),
    .mode       (mode),
    .mute       (mute),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: stable run length, current mode, strobes left to mute
  int m_mode = 0;
  int m_last = 0;
  int m_len = 0;
  int m_left = 0;
  bit m_valid = 1'b0;

  function automatic int want_mode(input logic [2:0] k);
    case (k)
      3'b110:  return 1;
      3'b101:  return 2;
      3'b011:  return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int r;
    r = want_mode(key_n);
    if (reset) begin
      m_mode = 0;
      m_left = 0;
      m_last = r;
      m_len  = 0;
    end else begin
      if (r == m_last) begin
        if (m_len <= DEB) m_len = m_len + 1;
      end else begin
        m_len = 1;
      end
      m_last = r;
      if (m_len == DEB && r != m_mode) begin
        m_mode = r;
        m_left = SE * SET;
      end else if (read_ready && write_ready && m_left > 0) begin
        m_left = m_left - 1;
      end
    end
    m_valid = 1'b1;
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("read", int'(read), int'(read_ready && write_ready && !reset));
      check("write", int'(write), int'(read_ready && write_ready && !reset));
      check("mode", int'(mode), m_mode);
      check("mute", int'(mute), int'(m_left > 0));
      check("busy", int'(busy), int'(!reset && (m_last != m_mode || m_left > 0)));
      check("state", int'(fsm_state), int'(m_left > 0));
    end
  end

  // driver
  task automatic tick(input logic [2:0] k, input logic rr, input logic wr);
    @(negedge clk);
    #2;
    key_n       = k;
    read_ready  = rr;
    write_ready = wr;
  endtask

  initial begin
    // reset with codec ready
    repeat (3) tick(3'b111, 1'b1, 1'b1);
    check("rst_read", int'(read), 0);
    check("rst_write", int'(write), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_mute", int'(mute), 0);
    tick(3'b111, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("post_rst_read", int'(read), 1);
    check("post_rst_write", int'(write), 1);
    repeat (2) tick(3'b111, 1'b0, 1'b0);

    // NOISY accepted on 4th edge, then 3 strobes of mute
    repeat (4) tick(3'b110, 1'b0, 1'b0);
    tick(3'b110, 1'b1, 1'b1);
    check("noisy_mode", int'(mode), 1);
    check("noisy_mute", int'(mute), SE);
    tick(3'b110, 1'b1, 1'b1);
    tick(3'b110, 1'b1, 1'b1);
    check("noisy_mute_2strobes", int'(mute), SE);
    tick(3'b110, 1'b0, 1'b0);
    check("noisy_unmute", int'(mute), 0);

    // release back to RAW
    repeat (4) tick(3'b111, 1'b0, 1'b0);
    repeat (3) tick(3'b111, 1'b1, 1'b1);
    tick(3'b111, 1'b0, 1'b0);
    check("raw_mode", int'(mode), 0);
    check("raw_mute", int'(mute), 0);

    // bouncing key never reaches 4 stable clocks
    for (int i = 0; i < 10; i++) begin
      repeat (2) tick((i % 2 == 0) ? 3'b101 : 3'b111, 1'b1, 1'b1);
    end
    tick(3'b111, 1'b0, 1'b0);
    check("bounce_mode", int'(mode), 0);
    check("bounce_mute", int'(mute), 0);
    check("bounce_busy", int'(busy), 0);

    // FIR, 2 strobes, then NSAMP restarts the settle
    repeat (4) tick(3'b101, 1'b0, 1'b0);
    tick(3'b101, 1'b1, 1'b1);
    check("fir_mode", int'(mode), 2);
    check("fir_mute", int'(mute), SE);
    tick(3'b101, 1'b1, 1'b1);
    repeat (4) tick(3'b011, 1'b0, 1'b0);
    tick(3'b011, 1'b1, 1'b1);
    check("nsamp_mode", int'(mode), 3);
    check("nsamp_mute", int'(mute), SE);
    tick(3'b011, 1'b1, 1'b1);
    tick(3'b011, 1'b1, 1'b1);
    check("nsamp_mute_2strobes", int'(mute), SE);
    tick(3'b011, 1'b0, 1'b0);
    check("nsamp_unmute", int'(mute), 0);

    // strobe on the accept edge is not counted
    repeat (3) tick(3'b110, 1'b0, 1'b0);
    tick(3'b110, 1'b1, 1'b1);
    tick(3'b110, 1'b1, 1'b1);
    check("coinc_mode", int'(mode), 1);
    check("coinc_mute", int'(mute), SE);
    tick(3'b110, 1'b1, 1'b1);
    tick(3'b110, 1'b1, 1'b1);
    check("coinc_mute_2strobes", int'(mute), SE);
    tick(3'b110, 1'b0, 1'b0);
    check("coinc_unmute", int'(mute), 0);

    // NSAMP with strobes running throughout
    repeat (4) tick(3'b011, 1'b1, 1'b1);
    tick(3'b011, 1'b1, 1'b1);
    check("nsamp2_mode", int'(mode), 3);
    check("nsamp2_mute", int'(mute), SE);
    repeat (4) tick(3'b011, 1'b1, 1'b1);

    // reset in the middle of a settle
    repeat (4) tick(3'b101, 1'b0, 1'b0);
    tick(3'b101, 1'b0, 1'b0);
    check("pre_abort_mute", int'(mute), SE);
    reset = 1'b1;
    #1;
    check("abort_mute", int'(mute), 0);
    check("abort_busy", int'(busy), 0);
    tick(3'b101, 1'b0, 1'b0);
    reset = 1'b0;
    tick(3'b101, 1'b0, 1'b0);
    check("abort_state", int'(fsm_state), 0);
    check("abort_mode", int'(mode), 0);
    repeat (8) tick(3'b111, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
